// File: rtl/div_unit_iter_pkg.sv
// Shared decode and condition/exception types for the iterative divide unit.
package div_unit_iter_pkg;

  typedef struct packed {
    logic div_signed;
    logic alter_OV;
    logic alter_CR0;
  } div_decode_t;

  typedef struct packed {
    logic OV;
    logic OV_valid;
    logic CA;
    logic CA_valid;
    logic CR0_valid;
  } cond_exception_t;

endpackage

// File: rtl/div_unit_iter.sv
// Iterative radix-2^BITS_PER_CYCLE restoring divider (divw/divwu + remainder).
// Pipeline: issue register (s0) -> iterative core -> output register.
// Divide-by-zero, MIN/-1 and zero dividend bypass the iterations.
module div_unit_iter
  import div_unit_iter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RS_ID_WIDTH    = 5,
  parameter int EARLY_OUT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [DATA_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0]  op2,
  input  div_decode_t            control,
  input  logic                   rem_mode,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [DATA_WIDTH-1:0]  result,
  output cond_exception_t        cr0_xer
);

  localparam int W    = DATA_WIDTH;
  localparam int B    = BITS_PER_CYCLE;
  localparam int KMAX = W / B;
  localparam int CW   = $clog2(KMAX + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  // Leading-zero count of the dividend magnitude
  function automatic int count_lz(input logic [W-1:0] v);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction

  // Stage 0 registers
  logic                   s0_valid_q, s0_valid_d;
  logic [RS_ID_WIDTH-1:0] s0_id_q;
  logic [4:0]             s0_addr_q;
  logic [W-1:0]           s0_op1_q, s0_op2_q;
  div_decode_t            s0_ctrl_q;
  logic                   s0_rem_q;

  // Core registers
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           acc_q, quo_q, dvs_q, res_mag_q;
  logic                   neg_q, rem_q, ov_q, aov_q, acr_q;
  logic [RS_ID_WIDTH-1:0] id_q;
  logic [4:0]             addr_q;

  // Output registers
  logic                   out_valid_q;
  logic [RS_ID_WIDTH-1:0] out_id_q;
  logic [4:0]             out_addr_q;
  logic [W-1:0]           out_res_q;
  cond_exception_t        out_xer_q;

  logic          accept, core_load, last_iter, out_load;
  logic          sign1, sign2, div_zero, min_neg1, bypass;
  logic [W-1:0]  mag1, mag2, acc_n, quo_n;
  logic [W:0]    trial;
  int            lz_al;
  logic [CW-1:0] k_init;

  // Handshake and occupancy: the core is free only in IDLE (DONE holds the result)
  always_comb begin
    core_load   = (state_q == IDLE) & s0_valid_q;
    last_iter   = (state_q == ITER) & (cnt_q == CW'(1));
    out_load    = (state_q == DONE) & (~out_valid_q | output_ready);
    input_ready = ~s0_valid_q | core_load;
    accept      = input_valid & input_ready;
    s0_valid_d  = accept | (s0_valid_q & ~core_load);
  end

  // Operand preparation: sign-magnitude, bypass detection, early-out alignment
  always_comb begin
    sign1    = s0_ctrl_q.div_signed & s0_op1_q[W-1];
    sign2    = s0_ctrl_q.div_signed & s0_op2_q[W-1];
    mag1     = sign1 ? -s0_op1_q : s0_op1_q;
    mag2     = sign2 ? -s0_op2_q : s0_op2_q;
    div_zero = (s0_op2_q == '0);
    min_neg1 = s0_ctrl_q.div_signed & (s0_op1_q == {1'b1, {(W-1){1'b0}}}) & (&s0_op2_q);
    bypass   = div_zero | min_neg1 | (mag1 == '0);
    lz_al    = (EARLY_OUT != 0) ? (count_lz(mag1) / B) * B : 0;
    k_init   = CW'((W - lz_al) / B);
  end

  // One core cycle: BITS_PER_CYCLE chained restoring steps
  always_comb begin
    acc_n = acc_q;
    quo_n = quo_q;
    trial = '0;
    for (int i = 0; i < B; i++) begin
      trial = {acc_n, quo_n[W-1]};
      quo_n = {quo_n[W-2:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
      acc_n = trial[W-1:0];
    end
  end

  // Core next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (s0_valid_q) begin
        state_d = bypass ? DONE : ITER;
        cnt_d   = bypass ? '0 : k_init;
      end
      ITER: begin
        cnt_d = cnt_q - CW'(1);
        if (last_iter) state_d = DONE;
      end
      DONE: if (out_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: valids, FSM and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stage 0 boundary: capture issued operation
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_id_q   <= rs_id_in;
      s0_addr_q <= result_reg_addr_in;
      s0_op1_q  <= op1;
      s0_op2_q  <= op2;
      s0_ctrl_q <= control;
      s0_rem_q  <= rem_mode;
    end
  end

  // Core boundary: load operands, iterate, latch final magnitude
  always_ff @(posedge clk) begin
    if (core_load) begin
      acc_q  <= '0;
      quo_q  <= mag1 << lz_al;
      dvs_q  <= mag2;
      neg_q  <= s0_rem_q ? sign1 : (sign1 ^ sign2);
      rem_q  <= s0_rem_q;
      ov_q   <= div_zero | min_neg1;
      aov_q  <= s0_ctrl_q.alter_OV;
      acr_q  <= s0_ctrl_q.alter_CR0;
      id_q   <= s0_id_q;
      addr_q <= s0_addr_q;
      if (bypass) res_mag_q <= '0;
    end else if (state_q == ITER) begin
      acc_q <= acc_n;
      quo_q <= quo_n;
      if (last_iter) res_mag_q <= rem_q ? acc_n : quo_n;
    end
  end

  // Output boundary: apply sign and hold while writeback stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_addr_q  <= '0;
      out_res_q   <= '0;
      out_xer_q   <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_id_q    <= id_q;
      out_addr_q  <= addr_q;
      out_res_q   <= (neg_q && (res_mag_q != '0)) ? -res_mag_q : res_mag_q;
      out_xer_q   <= '{OV: ov_q, OV_valid: aov_q, CA: 1'b0, CA_valid: 1'b0, CR0_valid: acr_q};
    end else if (output_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign output_valid        = out_valid_q;
  assign rs_id_out           = out_id_q;
  assign result_reg_addr_out = out_addr_q;
  assign result              = out_res_q;
  assign cr0_xer             = out_xer_q;

endmodule

// File: doc/div_unit_iter.md
Name: div_unit_iter

Overview:
- Parametrised successor of the single-radix 32-bit divide unit; executes divw/divwu plus a remainder mode in a reservation-station-fed execution slot.
- Generalised in operand width and digits retired per cycle (radix 2^BITS_PER_CYCLE restoring).
- Optional early-out skips leading-zero dividend digits, giving variable latency.
- Sits behind the RS issue port; drives the CDB/writeback arbiter with valid/ready.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, quotient bits retired per core cycle; legal values 1, 2, 4.
- RS_ID_WIDTH, 5, reservation-station tag width.
- EARLY_OUT, 1, 1 = skip aligned leading-zero digits of dividend magnitude; 0 = fixed iteration count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- input_valid  in  1  issue request.
- input_ready  out  1  unit can accept this cycle.
- rs_id_in  in  RS_ID_WIDTH  tag.
- result_reg_addr_in  in  5  destination GPR.
- op1  in  DATA_WIDTH  dividend.
- op2  in  DATA_WIDTH  divisor.
- control  in  div_decode_t  div_signed, alter_OV, alter_CR0.
- rem_mode  in  1  1 = return remainder instead of quotient.
- output_valid  out  1  result valid.
- output_ready  in  1  writeback accepts.
- rs_id_out  out  RS_ID_WIDTH  tag of result.
- result_reg_addr_out  out  5  destination GPR.
- result  out  DATA_WIDTH  quotient or remainder, two's complement.
- cr0_xer  out  cond_exception_t  OV/OV_valid, CA=0/CA_valid=0, CR0_valid.

Behaviour:
- Reset: output_valid=0, result=0, rs_id_out=0, result_reg_addr_out=0, cr0_xer all 0. All pipeline valids, busy, counters cleared. Reset mid-operation discards all in-flight ops. input_ready=1 in the first cycle after reset.
- Stage 0 (input reg): captured on the accept edge N (input_valid & input_ready).
  - input_ready = ~s0_valid | s0_advances. s0 advances when the core is IDLE.
- Core load (edge N+1): operands converted to sign-magnitude when div_signed; unsigned ops have magnitude = operand.
  - Result sign: quotient sign = sign1^sign2; remainder sign = sign1.
- Bypass cases, decided at load: the result register is written at N+1, with no core cycles.
  - Divisor 0: result 0, OV=1.
  - Signed MIN / -1: result 0, OV=1.
  - Dividend magnitude 0: result 0, OV=0.
- Core FSM states:
  - IDLE: load when s0_valid and not bypass -> ITER.
  - ITER: each cycle performs BITS_PER_CYCLE chained restoring steps on a (DATA_WIDTH+1)-bit accumulator. The counter is decremented by 1.
  - DONE: the final iteration writes the final quotient/remainder register and sets result_valid, then returns to IDLE.
  - If result_valid is set and not drained (output stage stalled), the core holds in DONE and does not overwrite.
- Iteration count K:
  - EARLY_OUT=0: K = DATA_WIDTH/BITS_PER_CYCLE.
  - EARLY_OUT=1: lz = count of leading zeros of dividend magnitude, rounded down to a multiple of BITS_PER_CYCLE. The dividend is pre-shifted by lz, and K = (DATA_WIDTH-lz)/BITS_PER_CYCLE (>=1, since zero dividend is bypassed).
- Latency (accept edge N to output_valid high after edge):
  - Normal: N+K+2.
  - Bypass: N+2.
- Output stage:
  - Loads when (~output_valid & result_valid) | (output_valid & output_ready).
  - Outputs hold stable while output_valid & ~output_ready.
  - result = two's-complement negate of magnitude when the result sign = 1 and magnitude != 0.
- cr0_xer fields:
  - OV_valid = alter_OV; OV as above.
  - CR0_valid = alter_CR0.
  - CA/CA_valid = 0.
- Simultaneous events:
  - Output drain and a new result_valid in the same cycle: the new result is loaded.
  - Core finishing while s0 holds the next op: the next op loads on the edge after DONE drains.
- Ordering: strictly in order; at most 3 ops in flight (s0, core, output).

Test Plan:
- W=32, B=1, EARLY_OUT=0, unsigned 100/7, rem_mode=0 -> result=14, OV=0, output_valid at N+34; rem_mode=1 -> result=2.
- W=32, B=2, EARLY_OUT=1, signed -100/7 -> quotient 0xFFFFFFF2 (-14); remainder 0xFFFFFFFE (-2); K=4 (lz=24), output_valid at N+6.
- Signed 0x80000000 / 0xFFFFFFFF, alter_OV=1 -> result 0, OV=1, OV_valid=1, output at N+2. Any op with divisor 0 -> result 0, OV=1.
- Back-to-back issue of 3 ops with output_ready=0 for 50 cycles -> input_ready drops after 3rd accept; outputs held stable; release -> results in issue order with correct rs_id_out/result_reg_addr_out.
- Assert rst mid-ITER with output_valid pending -> next cycle output_valid=0, all outputs 0, input_ready=1; fresh op 9/3 afterwards returns 3.
- W=64, B=4, unsigned 0xFFFFFFFFFFFFFFFF / 3 -> 0x5555555555555555, K=16, output at N+18.
